// File: rtl/wbm_rr_arbiter_if.sv
// wbm_rr_arbiter_if: requester-side and downstream Wishbone signals of the round-robin arbiter
interface wbm_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0]    m_cyc_i;
  logic [NUM_MASTERS-1:0]    m_stb_i;
  logic [NUM_MASTERS-1:0]    m_we_i;
  logic [4*NUM_MASTERS-1:0]  m_sel_i;
  logic [32*NUM_MASTERS-1:0] m_adr_i;
  logic [32*NUM_MASTERS-1:0] m_dat_i;
  logic [31:0]               m_dat_o;
  logic [NUM_MASTERS-1:0]    m_ack_o;
  logic [NUM_MASTERS-1:0]    m_err_o;
  logic                      s_cyc_o;
  logic                      s_stb_o;
  logic                      s_we_o;
  logic [3:0]                s_sel_o;
  logic [31:0]               s_adr_o;
  logic [31:0]               s_dat_o;
  logic [31:0]               s_dat_i;
  logic                      s_ack_i;
  logic                      s_err_i;
  logic [NUM_MASTERS-1:0]    grant_o;
  // arbiter view: masters downstream, serves the requesters
  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i, s_err_i,
    output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, grant_o
  );
  // environment view: requesters plus downstream slave
  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i, s_err_i,
    input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, grant_o
  );
endinterface

// File: rtl/wbm_rr_arbiter.sv
// wbm_rr_arbiter: round-robin Wishbone classic arbiter with cyc bus lock and per-beat timeout
// Reset release is assumed to be already synchronous to wb_clk_i.
module wbm_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 1024
) (
  input logic             wb_clk_i,
  input logic             wb_rst_n_i,
  wbm_rr_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT, ACK, LOCK} state_t;
  state_t state, state_d;
  logic [IW-1:0] ptr, ptr_d, own, own_d, win, src, nxt;
  logic [CW-1:0] cnt, cnt_d;
  logic [NUM_MASTERS-1:0] req, grant_d, ack_d, err_d;
  logic cyc_d, stb_d, we_d, any, tmo, rel, beat, done, ack_hit;
  logic [3:0] sel_d;
  logic [31:0] adr_d, dat_d, mdat_d;
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v >= NUM_MASTERS ? v - NUM_MASTERS : v);
  endfunction
  assign req = bus.m_cyc_i & bus.m_stb_i;
  assign tmo = cnt == CW'(TIMEOUT - 1);
  assign nxt = own == IW'(NUM_MASTERS - 1) ? '0 : own + 1'b1;
  assign src = state == IDLE ? win : own;
  assign rel = (state == WAIT && !bus.m_cyc_i[own]) ||
               (state == LOCK && (!bus.m_cyc_i[own] || (tmo && !bus.m_stb_i[own])));
  assign beat = (state == IDLE && any) || (state == LOCK && bus.m_stb_i[own]);
  assign done = bus.s_err_i || bus.s_ack_i || tmo;
  assign ack_hit = bus.s_ack_i && !bus.s_err_i;
  // first requester at or after the pointer, scanned downward so the nearest one wins
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (req[wrap(int'(ptr) + i)]) begin
        win = wrap(int'(ptr) + i);
        any = 1'b1;
      end
  end
  // next state and next register values; release beats new beat beats beat progress
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    own_d = own;
    cnt_d = cnt;
    grant_d = bus.grant_o;
    cyc_d = bus.s_cyc_o;
    stb_d = bus.s_stb_o;
    we_d = bus.s_we_o;
    sel_d = bus.s_sel_o;
    adr_d = bus.s_adr_o;
    dat_d = bus.s_dat_o;
    mdat_d = bus.m_dat_o;
    ack_d = '0;
    err_d = '0;
    if (rel) begin
      state_d = IDLE;
      ptr_d = nxt;
      cyc_d = 1'b0;
      stb_d = 1'b0;
      grant_d = '0;
    end else if (beat) begin
      state_d = WAIT;
      own_d = src;
      cnt_d = '0;
      cyc_d = 1'b1;
      stb_d = 1'b1;
      grant_d = '0;
      grant_d[src] = 1'b1;
      we_d = bus.m_we_i[src];
      sel_d = bus.m_sel_i[4*src +: 4];
      adr_d = bus.m_adr_i[32*src +: 32];
      dat_d = bus.m_dat_i[32*src +: 32];
    end else case (state)
      WAIT: if (done) begin
        state_d = ACK;
        stb_d = 1'b0;
        ack_d = ack_hit ? bus.grant_o : '0;
        err_d = ack_hit ? '0 : bus.grant_o;
        mdat_d = ack_hit ? bus.s_dat_i : bus.m_dat_o;
      end else cnt_d = cnt + 1'b1;
      ACK: begin
        state_d = LOCK;
        cnt_d = '0;
      end
      LOCK: cnt_d = cnt + 1'b1;
      default: ;
    endcase
  end
  // state and registered outputs, cleared asynchronously on reset
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      state <= IDLE;
      ptr <= '0;
      own <= '0;
      cnt <= '0;
      bus.grant_o <= '0;
      bus.s_cyc_o <= 1'b0;
      bus.s_stb_o <= 1'b0;
      bus.s_we_o <= 1'b0;
      bus.s_sel_o <= '0;
      bus.s_adr_o <= '0;
      bus.s_dat_o <= '0;
      bus.m_dat_o <= '0;
      bus.m_ack_o <= '0;
      bus.m_err_o <= '0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      own <= own_d;
      cnt <= cnt_d;
      bus.grant_o <= grant_d;
      bus.s_cyc_o <= cyc_d;
      bus.s_stb_o <= stb_d;
      bus.s_we_o <= we_d;
      bus.s_sel_o <= sel_d;
      bus.s_adr_o <= adr_d;
      bus.s_dat_o <= dat_d;
      bus.m_dat_o <= mdat_d;
      bus.m_ack_o <= ack_d;
      bus.m_err_o <= err_d;
    end
endmodule

// File: tb/tb_wbm_rr_arbiter.sv
// tb_wbm_rr_arbiter: directed scenarios for the round-robin Wishbone arbiter
module tb_wbm_rr_arbiter;
  localparam int N = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  wbm_rr_arbiter_if #(.NUM_MASTERS(N)) bus();
  wbm_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .bus       (bus)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    bus.m_cyc_i[i] = 1'b1;
    bus.m_stb_i[i] = 1'b1;
    bus.m_we_i[i] = we;
    bus.m_sel_i[4*i +: 4] = 4'hF;
    bus.m_adr_i[32*i +: 32] = adr;
    bus.m_dat_i[32*i +: 32] = dat;
  endtask

  task automatic drop(input int i);
    bus.m_cyc_i[i] = 1'b0;
    bus.m_stb_i[i] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    if ({bus.grant_o, bus.m_ack_o, bus.m_err_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %h want 0", {bus.grant_o, bus.m_ack_o, bus.m_err_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o});
    end
    n_cmp++;
    if ({bus.m_dat_o, bus.s_adr_o, bus.s_dat_o} !== 96'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {bus.m_dat_o, bus.s_adr_o, bus.s_dat_o});
    end
    n_cmp++;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_read;
    req(1, 1'b0, 32'h0000_1000, 32'h0);
    tick;
    if ({bus.grant_o, bus.s_stb_o, bus.s_cyc_o, bus.s_we_o, bus.s_adr_o} !== {4'b0010, 3'b110, 32'h1000}) begin
      n_bad++;
      $display("FAIL read_start: got %h want %h", {bus.grant_o, bus.s_stb_o, bus.s_cyc_o, bus.s_we_o, bus.s_adr_o}, {4'b0010, 3'b110, 32'h1000});
    end
    n_cmp++;
    bus.s_dat_i = 32'hDEAD_BEEF;
    tick;
    tick;
    if ({bus.s_stb_o, bus.m_ack_o} !== 5'b1_0000) begin
      n_bad++;
      $display("FAIL read_wait: got %b want 10000", {bus.s_stb_o, bus.m_ack_o});
    end
    n_cmp++;
    bus.s_ack_i = 1'b1;
    tick;
    bus.s_ack_i = 1'b0;
    if ({bus.m_ack_o, bus.m_err_o, bus.s_stb_o, bus.m_dat_o} !== {4'b0010, 4'b0000, 1'b0, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL read_ack: got %h want %h", {bus.m_ack_o, bus.m_err_o, bus.s_stb_o, bus.m_dat_o}, {4'b0010, 4'b0000, 1'b0, 32'hDEAD_BEEF});
    end
    n_cmp++;
    drop(1);
    tick;
    if ({bus.m_ack_o, bus.grant_o, bus.s_cyc_o} !== {4'b0000, 4'b0010, 1'b1}) begin
      n_bad++;
      $display("FAIL read_lock: got %b want 0000_0010_1", {bus.m_ack_o, bus.grant_o, bus.s_cyc_o});
    end
    n_cmp++;
    tick;
    if ({bus.grant_o, bus.s_cyc_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL read_release: got %b want 00000", {bus.grant_o, bus.s_cyc_o});
    end
    n_cmp++;
  endtask

  task automatic test_rr;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req(0, 1'b0, 32'hA0, 32'h0);
    req(2, 1'b0, 32'hA2, 32'h0);
    tick;
    if ({bus.grant_o, bus.s_adr_o} !== {4'b0001, 32'hA0}) begin
      n_bad++;
      $display("FAIL rr_first: got %h want %h", {bus.grant_o, bus.s_adr_o}, {4'b0001, 32'hA0});
    end
    n_cmp++;
    bus.s_ack_i = 1'b1;
    tick;
    bus.s_ack_i = 1'b0;
    if ({bus.m_ack_o, bus.m_dat_o} !== {4'b0001, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL rr_ack0: got %h want %h", {bus.m_ack_o, bus.m_dat_o}, {4'b0001, 32'hDEAD_BEEF});
    end
    n_cmp++;
    drop(0);
    tick;
    tick;
    req(0, 1'b0, 32'hA0, 32'h0);
    tick;
    if ({bus.grant_o, bus.s_adr_o} !== {4'b0100, 32'hA2}) begin
      n_bad++;
      $display("FAIL rr_second: got %h want %h", {bus.grant_o, bus.s_adr_o}, {4'b0100, 32'hA2});
    end
    n_cmp++;
    bus.s_ack_i = 1'b1;
    tick;
    bus.s_ack_i = 1'b0;
    if (bus.m_ack_o !== 4'b0100) begin
      n_bad++;
      $display("FAIL rr_ack2: got %b want 0100", bus.m_ack_o);
    end
    n_cmp++;
    drop(2);
    tick;
    tick;
    tick;
    if ({bus.grant_o, bus.s_adr_o} !== {4'b0001, 32'hA0}) begin
      n_bad++;
      $display("FAIL rr_regrant: got %h want %h", {bus.grant_o, bus.s_adr_o}, {4'b0001, 32'hA0});
    end
    n_cmp++;
    bus.s_ack_i = 1'b1;
    tick;
    bus.s_ack_i = 1'b0;
    drop(0);
    tick;
    tick;
  endtask

  task automatic test_back_to_back;
    req(0, 1'b0, 32'hB0, 32'h0);
    req(3, 1'b1, 32'h10, 32'd1);
    tick;
    for (int b = 0; b < 4; b++) begin
      if ({bus.s_stb_o, bus.s_we_o, bus.grant_o, bus.s_adr_o, bus.s_dat_o} !== {2'b11, 4'b1000, 32'(16 + 4*b), 32'(b + 1)}) begin
        n_bad++;
        $display("FAIL b2b_beat%0d: got %h want %h", b, {bus.s_stb_o, bus.s_we_o, bus.grant_o, bus.s_adr_o, bus.s_dat_o}, {2'b11, 4'b1000, 32'(16 + 4*b), 32'(b + 1)});
      end
      n_cmp++;
      bus.s_ack_i = 1'b1;
      tick;
      bus.s_ack_i = 1'b0;
      if (bus.m_ack_o !== 4'b1000) begin
        n_bad++;
        $display("FAIL b2b_ack%0d: got %b want 1000", b, bus.m_ack_o);
      end
      n_cmp++;
      if (b < 3) req(3, 1'b1, 32'(16 + 4*(b + 1)), 32'(b + 2));
      else drop(3);
      tick;
      if ({bus.s_cyc_o, bus.grant_o} !== 5'b1_1000) begin
        n_bad++;
        $display("FAIL b2b_lock%0d: got %b want 11000", b, {bus.s_cyc_o, bus.grant_o});
      end
      n_cmp++;
      tick;
    end
    if ({bus.grant_o, bus.s_cyc_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL b2b_release: got %b want 00000", {bus.grant_o, bus.s_cyc_o});
    end
    n_cmp++;
    tick;
    if ({bus.grant_o, bus.s_adr_o} !== {4'b0001, 32'hB0}) begin
      n_bad++;
      $display("FAIL b2b_next: got %h want %h", {bus.grant_o, bus.s_adr_o}, {4'b0001, 32'hB0});
    end
    n_cmp++;
    bus.s_ack_i = 1'b1;
    tick;
    bus.s_ack_i = 1'b0;
    drop(0);
    tick;
    tick;
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    req(1, 1'b0, 32'h2000, 32'h0);
    tick;
    if ({bus.s_stb_o, bus.grant_o} !== 5'b1_0010) begin
      n_bad++;
      $display("FAIL to_start: got %b want 10010", {bus.s_stb_o, bus.grant_o});
    end
    n_cmp++;
    for (int c = 0; c < TO - 1; c++) begin
      tick;
      if (bus.m_err_o !== 4'b0 || bus.s_stb_o !== 1'b1) early++;
    end
    if (early !== 0) begin
      n_bad++;
      $display("FAIL to_early: got %0d early cycles want 0", early);
    end
    n_cmp++;
    tick;
    if ({bus.m_err_o, bus.m_ack_o, bus.s_stb_o} !== {4'b0010, 4'b0000, 1'b0}) begin
      n_bad++;
      $display("FAIL to_err: got %b want 0010_0000_0", {bus.m_err_o, bus.m_ack_o, bus.s_stb_o});
    end
    n_cmp++;
    drop(1);
    tick;
    if (bus.m_err_o !== 4'b0) begin
      n_bad++;
      $display("FAIL to_pulse: got %b want 0000", bus.m_err_o);
    end
    n_cmp++;
    tick;
    req(2, 1'b0, 32'h3000, 32'h0);
    tick;
    if ({bus.grant_o, bus.s_adr_o} !== {4'b0100, 32'h3000}) begin
      n_bad++;
      $display("FAIL to_recover: got %h want %h", {bus.grant_o, bus.s_adr_o}, {4'b0100, 32'h3000});
    end
    n_cmp++;
    bus.s_ack_i = 1'b1;
    tick;
    bus.s_ack_i = 1'b0;
    if (bus.m_ack_o !== 4'b0100) begin
      n_bad++;
      $display("FAIL to_recover_ack: got %b want 0100", bus.m_ack_o);
    end
    n_cmp++;
    drop(2);
    tick;
    tick;
  endtask

  task automatic test_err_ack;
    req(3, 1'b0, 32'h40, 32'h0);
    tick;
    if (bus.grant_o !== 4'b1000) begin
      n_bad++;
      $display("FAIL ea_grant: got %b want 1000", bus.grant_o);
    end
    n_cmp++;
    bus.s_ack_i = 1'b1;
    bus.s_err_i = 1'b1;
    tick;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    if ({bus.m_err_o, bus.m_ack_o} !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL ea_errwins: got %b want 1000_0000", {bus.m_err_o, bus.m_ack_o});
    end
    n_cmp++;
    drop(3);
    tick;
    tick;
  endtask

  task automatic test_abort;
    req(0, 1'b0, 32'h50, 32'h0);
    tick;
    if (bus.grant_o !== 4'b0001) begin
      n_bad++;
      $display("FAIL ab_grant: got %b want 0001", bus.grant_o);
    end
    n_cmp++;
    drop(0);
    tick;
    if ({bus.grant_o, bus.s_cyc_o, bus.s_stb_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL ab_drop: got %b want 000000", {bus.grant_o, bus.s_cyc_o, bus.s_stb_o});
    end
    n_cmp++;
    bus.s_dat_i = 32'h0000_1234;
    bus.s_ack_i = 1'b1;
    tick;
    bus.s_ack_i = 1'b0;
    if ({bus.m_ack_o, bus.m_err_o, bus.m_dat_o} !== {8'b0, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL ab_lateack: got %h want %h", {bus.m_ack_o, bus.m_err_o, bus.m_dat_o}, {8'b0, 32'hDEAD_BEEF});
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid;
    req(0, 1'b0, 32'h60, 32'h0);
    req(1, 1'b0, 32'h61, 32'h0);
    req(2, 1'b0, 32'h62, 32'h0);
    tick;
    if ({bus.grant_o, bus.s_stb_o} !== 5'b0010_1) begin
      n_bad++;
      $display("FAIL rm_before: got %b want 00101", {bus.grant_o, bus.s_stb_o});
    end
    n_cmp++;
    #2;
    rst_n = 1'b0;
    #1;
    if ({bus.grant_o, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o, bus.m_dat_o, bus.s_adr_o} !== 78'd0) begin
      n_bad++;
      $display("FAIL rm_async: got %h want 0", {bus.grant_o, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o, bus.m_dat_o, bus.s_adr_o});
    end
    n_cmp++;
    rst_n = 1'b1;
    tick;
    if ({bus.grant_o, bus.s_adr_o} !== {4'b0001, 32'h60}) begin
      n_bad++;
      $display("FAIL rm_after: got %h want %h", {bus.grant_o, bus.s_adr_o}, {4'b0001, 32'h60});
    end
    n_cmp++;
    for (int i = 0; i < N; i++) drop(i);
    tick;
  endtask

  initial begin
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i = '0;
    bus.m_sel_i = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.s_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    test_reset;
    test_read;
    test_rr;
    test_back_to_back;
    test_timeout;
    test_err_ack;
    test_abort;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
